// File: rtl/apb_arbiter.sv
// Two-master APB arbiter with round-robin grant onto a single downstream APB port.
// Optional access-phase watchdog enabled by defining APB_ARB_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | no transfer; arbitrate between upstream requests
//   SETUP  | downstream setup phase with latched fields
//   ACCESS | downstream access phase, waiting for apbm_pready
//   RESP   | one-cycle upstream pready to the granted master
module apb_arbiter #(
  parameter int W_ADDR         = 16,
  parameter int W_DATA         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*W_ADDR-1:0] apbs_paddr,
  input  logic [1:0]          apbs_psel,
  input  logic [1:0]          apbs_penable,
  input  logic [1:0]          apbs_pwrite,
  input  logic [2*W_DATA-1:0] apbs_pwdata,
  output logic [1:0]          apbs_pready,
  output logic [2*W_DATA-1:0] apbs_prdata,
  output logic [1:0]          apbs_pslverr,
  output logic [W_ADDR-1:0]   apbm_paddr,
  output logic                apbm_psel,
  output logic                apbm_penable,
  output logic                apbm_pwrite,
  output logic [W_DATA-1:0]   apbm_pwdata,
  input  logic                apbm_pready,
  input  logic [W_DATA-1:0]   apbm_prdata,
  input  logic                apbm_pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            r_state, w_next;
  logic              r_grant, r_last, w_pick, w_timeout;
  logic [W_ADDR-1:0] r_addr;
  logic [W_DATA-1:0] r_wdata, r_rdata;
  logic              r_write, r_slverr;
  logic              w_unused;

  // penable from the masters carries no information the arbiter needs
  assign w_unused = ^apbs_penable;

  // on contention the master not served last wins
  always_comb begin
    w_pick = apbs_psel[1];
    if (apbs_psel == 2'b11) w_pick = ~r_last;
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_cnt <= '0;
    else if (r_state == SETUP)                  r_cnt <= '0;
    else if (r_state == ACCESS && !apbm_pready) r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == ACCESS) && !apbm_pready &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && |apbs_psel) begin
        r_grant <= w_pick;
        r_addr  <= w_pick ? apbs_paddr[2*W_ADDR-1:W_ADDR] : apbs_paddr[W_ADDR-1:0];
        r_write <= apbs_pwrite[w_pick];
        r_wdata <= w_pick ? apbs_pwdata[2*W_DATA-1:W_DATA] : apbs_pwdata[W_DATA-1:0];
      end
      if (r_state == ACCESS && apbm_pready) begin
        r_rdata  <= apbm_prdata;
        r_slverr <= apbm_pslverr;
      end else if (w_timeout) begin
        r_rdata  <= '0;
        r_slverr <= 1'b1;
      end
      if (r_state == RESP) r_last <= r_grant;
    end
  end

  always_comb begin
    w_next       = r_state;
    apbs_pready  = '0;
    apbs_prdata  = '0;
    apbs_pslverr = '0;
    apbm_paddr   = '0;
    apbm_psel    = 1'b0;
    apbm_penable = 1'b0;
    apbm_pwrite  = 1'b0;
    apbm_pwdata  = '0;
    case (r_state)
      IDLE: if (|apbs_psel) w_next = SETUP;
      SETUP: begin
        apbm_psel   = 1'b1;
        apbm_paddr  = r_addr;
        apbm_pwrite = r_write;
        apbm_pwdata = r_wdata;
        w_next      = ACCESS;
      end
      ACCESS: begin
        apbm_psel    = 1'b1;
        apbm_penable = 1'b1;
        apbm_paddr   = r_addr;
        apbm_pwrite  = r_write;
        apbm_pwdata  = r_wdata;
        if (apbm_pready || w_timeout) w_next = RESP;
      end
      RESP: begin
        apbs_pready[r_grant]  = 1'b1;
        apbs_pslverr[r_grant] = r_slverr;
        if (r_grant) apbs_prdata[2*W_DATA-1:W_DATA] = r_rdata;
        else         apbs_prdata[W_DATA-1:0]        = r_rdata;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter; inputs change and outputs are sampled on the falling edge.
module tb_apb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] apbs_paddr;
  logic [1:0]  apbs_psel, apbs_penable, apbs_pwrite;
  logic [63:0] apbs_pwdata;
  logic [1:0]  apbs_pready, apbs_pslverr;
  logic [63:0] apbs_prdata;
  logic [15:0] apbm_paddr;
  logic        apbm_psel, apbm_penable, apbm_pwrite;
  logic [31:0] apbm_pwdata;
  logic        apbm_pready, apbm_pslverr;
  logic [31:0] apbm_prdata;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_arbiter #(.W_ADDR(16), .W_DATA(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .apbs_paddr(apbs_paddr), .apbs_psel(apbs_psel), .apbs_penable(apbs_penable),
    .apbs_pwrite(apbs_pwrite), .apbs_pwdata(apbs_pwdata), .apbs_pready(apbs_pready),
    .apbs_prdata(apbs_prdata), .apbs_pslverr(apbs_pslverr),
    .apbm_paddr(apbm_paddr), .apbm_psel(apbm_psel), .apbm_penable(apbm_penable),
    .apbm_pwrite(apbm_pwrite), .apbm_pwdata(apbm_pwdata), .apbm_pready(apbm_pready),
    .apbm_prdata(apbm_prdata), .apbm_pslverr(apbm_pslverr)
  );

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    apbs_paddr = '0; apbs_psel = '0; apbs_penable = '0; apbs_pwrite = '0; apbs_pwdata = '0;
    apbm_pready = 1'b0; apbm_prdata = '0; apbm_pslverr = 1'b0;
    repeat (2) nc();
    chk("rst_psel", apbm_psel, 0);
    chk("rst_penable", apbm_penable, 0);
    chk("rst_paddr", apbm_paddr, 0);
    chk("rst_pready", apbs_pready, 0);
    chk("rst_prdata", apbs_prdata, 0);
    rst_n = 1'b1;

    // master 0 read, zero-wait slave
    nc();
    apbs_psel = 2'b01; apbs_paddr = {16'h0, 16'h0040};
    apbm_pready = 1'b1; apbm_prdata = 32'hDEADBEEF;
    chk("rd_n_psel", apbm_psel, 0);
    nc();
    chk("rd_setup_psel", apbm_psel, 1);
    chk("rd_setup_penable", apbm_penable, 0);
    chk("rd_setup_paddr", apbm_paddr, 16'h0040);
    nc();
    chk("rd_access_penable", apbm_penable, 1);
    chk("rd_access_pready", apbs_pready, 0);
    nc();
    chk("rd_resp_pready", apbs_pready, 2'b01);
    chk("rd_resp_prdata", apbs_prdata, 64'h0000_0000_DEAD_BEEF);
    chk("rd_resp_dn_psel", apbm_psel, 0);
    chk("rd_resp_dn_paddr", apbm_paddr, 0);
    apbs_psel = 2'b00;
    nc();
    chk("rd_idle_pready", apbs_pready, 0);
    chk("rd_idle_prdata", apbs_prdata, 0);

    // master 1 write, 3 wait states, upstream fields change mid-transfer
    nc();
    apbs_psel = 2'b10; apbs_pwrite = 2'b10;
    apbs_paddr = {16'h0100, 16'h0}; apbs_pwdata = {32'h1234_5678, 32'h0};
    apbm_pready = 1'b0;
    nc();
    chk("wr_setup_pwdata", apbm_pwdata, 32'h1234_5678);
    chk("wr_setup_pwrite", apbm_pwrite, 1);
    chk("wr_setup_paddr", apbm_paddr, 16'h0100);
    apbs_pwdata = {32'hFFFF_0000, 32'h0}; apbs_paddr = {16'hBEEF, 16'h0};
    nc();
    chk("wr_acc1_pwdata", apbm_pwdata, 32'h1234_5678);
    chk("wr_acc1_penable", apbm_penable, 1);
    nc();
    chk("wr_acc2_pready", apbs_pready, 0);
    nc();
    chk("wr_acc3_pwdata", apbm_pwdata, 32'h1234_5678);
    chk("wr_acc3_paddr", apbm_paddr, 16'h0100);
    nc();
    chk("wr_acc4_penable", apbm_penable, 1);
    chk("wr_acc4_pready", apbs_pready, 0);
    apbm_pready = 1'b1; apbm_prdata = 32'h0BAD_F00D;
    nc();
    chk("wr_resp_pready", apbs_pready, 2'b10);
    chk("wr_resp_prdata", apbs_prdata, 64'h0BAD_F00D_0000_0000);
    chk("wr_resp_pwdata", apbm_pwdata, 0);
    chk("wr_resp_pwrite", apbm_pwrite, 0);
    apbs_psel = 2'b00; apbs_pwrite = 2'b00;
    nc();

    // slave error response to master 0
    nc();
    apbs_psel = 2'b01; apbs_paddr = {16'h0, 16'h0080};
    apbm_pslverr = 1'b1; apbm_prdata = 32'hA5A5_A5A5;
    nc();
    nc();
    chk("err_access_pslverr", apbs_pslverr, 0);
    nc();
    chk("err_resp_pslverr", apbs_pslverr, 2'b01);
    chk("err_resp_prdata", apbs_prdata, 64'h0000_0000_A5A5_A5A5);
    chk("err_resp_pready", apbs_pready, 2'b01);
    apbs_psel = 2'b00; apbm_pslverr = 1'b0;
    nc();
    chk("err_idle_pslverr", apbs_pslverr, 0);

    // master 1 raises then withdraws its request while master 0 is served
    nc();
    apbs_psel = 2'b01;
    nc();
    apbs_psel = 2'b11;
    nc();
    apbs_psel = 2'b01;
    nc();
    chk("wd_resp_pready", apbs_pready, 2'b01);
    apbs_psel = 2'b00;
    nc();
    chk("wd_idle_psel", apbm_psel, 0);
    nc();
    chk("wd_no_grant_psel", apbm_psel, 0);

    // contention after reset: grants alternate 0,1,0,1 with one idle cycle between
    rst_n = 1'b0;
    nc();
    rst_n = 1'b1;
    nc();
    apbs_psel = 2'b11; apbs_paddr = {16'h2222, 16'h1111};
    apbm_pready = 1'b1; apbm_prdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      nc();
      chk($sformatf("rr%0d_setup_paddr", k), apbm_paddr, (k % 2 == 0) ? 16'h1111 : 16'h2222);
      nc();
      nc();
      chk($sformatf("rr%0d_resp_pready", k), apbs_pready, (k % 2 == 0) ? 2'b01 : 2'b10);
      nc();
      chk($sformatf("rr%0d_idle_psel", k), apbm_psel, 0);
    end
    apbs_psel = 2'b00;
    nc();

    // slave never ready
    nc();
    apbs_psel = 2'b01; apbs_paddr = {16'h0, 16'h0300};
    apbm_pready = 1'b0; apbm_prdata = 32'h7777_7777;
    nc();
    nc();
`ifdef APB_ARB_TIMEOUT_EN
    repeat (7) nc();
    chk("to_last_access_penable", apbm_penable, 1);
    chk("to_last_access_pready", apbs_pready, 0);
    nc();
    chk("to_resp_pready", apbs_pready, 2'b01);
    chk("to_resp_pslverr", apbs_pslverr, 2'b01);
    chk("to_resp_prdata", apbs_prdata, 0);
    chk("to_resp_dn_psel", apbm_psel, 0);
    nc();
    nc();
    nc();
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      nc();
      if (apbs_pready !== 2'b00) seen = 1'b1;
    end
    chk("stall_no_pready", seen, 0);
`endif
    chk("stall_access_penable", apbm_penable, 1);

    // asynchronous reset in the middle of ACCESS
    #2 rst_n = 1'b0;
    #1;
    chk("arst_psel", apbm_psel, 0);
    chk("arst_penable", apbm_penable, 0);
    apbs_psel = 2'b00;
    nc();
    rst_n = 1'b1;
    nc();
    chk("arst_after_pready", apbs_pready, 0);
    chk("arst_after_psel", apbm_psel, 0);
    apbs_psel = 2'b10; apbs_paddr = {16'h0500, 16'h0}; apbm_pready = 1'b1;
    nc();
    chk("arst_new_setup_psel", apbm_psel, 1);
    chk("arst_new_setup_paddr", apbm_paddr, 16'h0500);
    apbs_psel = 2'b00;
    nc();
    nc();
    chk("arst_new_resp_pready", apbs_pready, 2'b10);
    nc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
